// File: rtl/amplitude_restorer.sv
// amplitude_restorer
//   Measures the peak of an unsigned sample stream over a window of WINDOW valid
//   samples, infers the upstream right-shift attenuation code (0..MAX_SHIFT) and
//   restores later samples by the matching left shift, saturating at full scale.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      1-cycle pulse: begin (or restart) a measurement window
//   validIn    dataIn holds a sample this cycle
//   dataIn     input sample (unsigned)
//   validOut   dataOut holds a restored sample (1 cycle after validIn)
//   dataOut    restored, saturated sample; held while validIn is low
//   shiftCode  shift currently applied
//   locked     shiftCode comes from a completed window
//   busy       measurement in progress (MEASURE or LOCK)
module amplitude_restorer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned MAX_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             validIn,
    input  logic [WIDTH-1:0] dataIn,
    output logic             validOut,
    output logic [WIDTH-1:0] dataOut,
    output logic [1:0]       shiftCode,
    output logic             locked,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WINDOW);
    localparam int unsigned EW = WIDTH + MAX_SHIFT;

    typedef enum logic [1:0] {StIdle, StMeasure, StLock, StTrack} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic [1:0]       shift_q, shift_d;
    logic             locked_q, locked_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    logic [1:0]       lock_code;
    logic [EW-1:0]    peak_ext;
    logic [EW-1:0]    shifted;
    logic [WIDTH-1:0] sat_val;

    // Largest k such that peak << k still fits in WIDTH bits. The condition is
    // monotonic in k, so the last passing k wins.
    always_comb begin
        lock_code = '0;
        peak_ext  = {{MAX_SHIFT{1'b0}}, peak_q};
        for (int unsigned k = 1; k <= MAX_SHIFT; k++) begin
            if (((peak_ext << k) >> WIDTH) == '0) begin
                lock_code = 2'(k);
            end
        end
    end

    // Restore path uses the registered code, so a sample in the LOCK cycle
    // still sees the previous code.
    always_comb begin
        shifted = {{MAX_SHIFT{1'b0}}, dataIn} << shift_q;
        sat_val = (|shifted[EW-1:WIDTH]) ? '1 : shifted[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        peak_d   = peak_q;
        shift_d  = shift_q;
        locked_d = locked_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StMeasure;
                    count_d = '0;
                    peak_d  = '0;
                end
            end
            StMeasure: begin
                // A restart takes priority over any sample in the same cycle.
                if (start) begin
                    count_d = '0;
                    peak_d  = '0;
                end else if (validIn) begin
                    if (dataIn > peak_q) begin
                        peak_d = dataIn;
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WINDOW - 1)) begin
                        state_d = StLock;
                    end
                end
            end
            StLock: begin
                shift_d  = lock_code;
                locked_d = 1'b1;
                state_d  = StTrack;
            end
            StTrack: begin
                if (start) begin
                    state_d = StMeasure;
                    count_d = '0;
                    peak_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            peak_q   <= '0;
            shift_q  <= '0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            peak_q   <= peak_d;
            shift_q  <= shift_d;
            locked_q <= locked_d;
            valid_q  <= validIn;
            if (validIn) begin
                data_q <= sat_val;
            end
        end
    end

    assign validOut  = valid_q;
    assign dataOut   = data_q;
    assign shiftCode = shift_q;
    assign locked    = locked_q;
    assign busy      = (state_q == StMeasure) || (state_q == StLock);

endmodule

// File: tb/tb_amplitude_restorer.sv
// Directed bench for amplitude_restorer with hand-computed expectations.
module tb_amplitude_restorer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       validIn = 1'b0;
    logic [7:0] dataIn = '0;
    logic       validOut;
    logic [7:0] dataOut;
    logic [1:0] shiftCode;
    logic       locked;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    amplitude_restorer #(
        .WIDTH    (8),
        .WINDOW   (256),
        .MAX_SHIFT(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .validIn  (validIn),
        .dataIn   (dataIn),
        .validOut (validOut),
        .dataOut  (dataOut),
        .shiftCode(shiftCode),
        .locked   (locked),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned d);
        validIn = 1'b1;
        dataIn  = 8'(d);
        step();
        validIn = 1'b0;
    endtask

    task automatic idle_cyc();
        validIn = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        start   = 1'b1;
        validIn = 1'b0;
        step();
        start   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_validOut"}, 32'(validOut), 0);
        check({tag, "_dataOut"}, 32'(dataOut), 0);
        check({tag, "_shiftCode"}, 32'(shiftCode), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int busy_bad;
        int sent;
        int c;

        // 1: reset
        #2 rst = 1'b1;
        #1 check_all_zero("rst_init");
        step();
        rst = 1'b0;
        send(77);
        check("t1_validOut", 32'(validOut), 1);
        check("t1_pass77", 32'(dataOut), 77);
        idle_cyc();
        check("t1_validOut_low", 32'(validOut), 0);
        check("t1_hold", 32'(dataOut), 77);

        // 2: ramp 0..31 -> code 3
        pulse_start();
        check("t2_busy_start", 32'(busy), 1);
        busy_bad = 0;
        for (int i = 0; i < 256; i++) begin
            send(i % 32);
            if (busy !== 1'b1) busy_bad++;
        end
        check("t2_busy_window", 32'(busy_bad), 0);
        check("t2_unlocked_in_lock", 32'(locked), 0);
        idle_cyc();
        check("t2_code", 32'(shiftCode), 3);
        check("t2_locked", 32'(locked), 1);
        check("t2_busy_track", 32'(busy), 0);
        send(20);
        check("t2_restore20", 32'(dataOut), 160);

        // 3: peak 100 -> code 1, then peak 255 -> code 0
        pulse_start();
        for (int i = 0; i < 256; i++) send((i == 130) ? 100 : (i % 64));
        idle_cyc();
        check("t3_code1", 32'(shiftCode), 1);
        send(50);
        check("t3_restore50", 32'(dataOut), 100);
        pulse_start();
        for (int i = 0; i < 256; i++) send((i == 7) ? 255 : 3);
        idle_cyc();
        check("t3_code0", 32'(shiftCode), 0);

        // 5: restart discards peak 200; gapped window of exactly 256 valid samples
        pulse_start();
        for (int i = 0; i < 100; i++) send((i == 50) ? 200 : 10);
        pulse_start();
        sent = 0;
        c = 0;
        while (sent < 255) begin
            if (c % 3 == 2) idle_cyc();
            else begin
                send(sent % 32);
                sent++;
            end
            c++;
        end
        idle_cyc();
        idle_cyc();
        check("t5_busy_at255", 32'(busy), 1);
        check("t5_code_at255", 32'(shiftCode), 0);
        send(5);
        check("t5_busy_lock", 32'(busy), 1);
        send(20);  // sample in LOCK cycle uses old code 0
        check("t5_lock_sample", 32'(dataOut), 20);
        check("t5_code3", 32'(shiftCode), 3);
        check("t5_busy_track", 32'(busy), 0);

        // 6: lock code 2, then re-measure to code 0 with locked held
        pulse_start();
        for (int i = 0; i < 256; i++) send(i % 64);
        idle_cyc();
        check("t6_code2", 32'(shiftCode), 2);
        pulse_start();
        check("t6_locked_measure", 32'(locked), 1);
        send(10);
        check("t6_old_code_applied", 32'(dataOut), 40);
        for (int i = 1; i < 256; i++) send((i == 255) ? 255 : 10);
        check("t6_code_in_lock", 32'(shiftCode), 2);
        check("t6_locked_in_lock", 32'(locked), 1);
        idle_cyc();
        check("t6_code0", 32'(shiftCode), 0);
        check("t6_locked_after", 32'(locked), 1);

        // 4: all-zero window -> code 3, saturation
        pulse_start();
        for (int i = 0; i < 256; i++) send(0);
        idle_cyc();
        check("t4_code3", 32'(shiftCode), 3);
        send(40);
        check("t4_sat40", 32'(dataOut), 255);
        send(31);
        check("t4_restore31", 32'(dataOut), 248);

        // Reset mid-window while locked
        pulse_start();
        for (int i = 0; i < 10; i++) send(9);
        validIn = 1'b1;
        dataIn  = 8'd9;
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        validIn = 1'b0;
        step();
        rst = 1'b0;
        send(77);
        check("rst_mid_pass77", 32'(dataOut), 77);
        check("rst_mid_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
